// File: rtl/vmicro16_timer_multi_apb.sv
// ---------------------------------------------------------------------------
// vmicro16_timer_multi_apb
//
// Multi-channel APB timer/counter slave. Each channel is an independent
// down-counter with a load register, an 8-bit prescaler (divide by PRE+1),
// one-shot or periodic mode, a sticky pending flag with overrun detection
// and a maskable interrupt line.
//
// Register map (per channel, S_PADDR[1:0]):
//   0 LOAD   R/W  reload value; writing also restarts count and prescaler
//   1 COUNT  RO   current count
//   2 CTRL   R/W  b0 EN, b1 PERIODIC, b2 IE, b3 FORCE (self-clearing),
//                 b15:8 PRE
//   3 STATUS R/W1C b0 PEND, b1 OVR
// Channel select is S_PADDR[2 +: clog2(CHANNELS)]; out-of-range channels
// read 0 and ignore writes.
//
// Ports:
//   clk, reset       single clock, asynchronous active-high reset
//   S_PADDR ..       APB slave port, zero wait states
//   S_PRDATA         read data, 0 outside an access phase
//   S_PREADY         S_PSELx & S_PENABLE
//   irq              per-channel pending & IE
//   int_data         per-channel constant k+1, DATA_WIDTH bits per slice
// ---------------------------------------------------------------------------
module vmicro16_timer_multi_apb #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BUS_WIDTH-1:0]           S_PADDR,
    input  logic                           S_PWRITE,
    input  logic                           S_PSELx,
    input  logic                           S_PENABLE,
    input  logic [DATA_WIDTH-1:0]          S_PWDATA,
    output logic [DATA_WIDTH-1:0]          S_PRDATA,
    output logic                           S_PREADY,
    output logic [CHANNELS-1:0]            irq,
    output logic [CHANNELS*DATA_WIDTH-1:0] int_data
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        REG_LOAD   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic            w_access;
    logic            w_wr;
    logic [CW-1:0]   w_ch;
    logic            w_ch_ok;
    reg_e            w_reg;
    logic            w_unused_addr;

    logic [DATA_WIDTH-1:0] w_rd [CHANNELS];

    assign w_access      = S_PSELx & S_PENABLE;
    assign w_wr          = w_access & S_PWRITE;
    assign w_ch          = S_PADDR[2 +: CW];
    assign w_reg         = reg_e'(S_PADDR[1:0]);
    assign w_ch_ok       = ({{(32-CW){1'b0}}, w_ch} < 32'(CHANNELS));
    assign w_unused_addr = ^S_PADDR;

    assign S_PREADY = w_access;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [DATA_WIDTH-1:0] r_load;
            logic [DATA_WIDTH-1:0] r_count;
            logic [7:0]            r_pcnt;
            logic [7:0]            r_pre;
            logic                  r_en;
            logic                  r_per;
            logic                  r_ie;
            logic                  r_pend;
            logic                  r_ovr;

            logic                  w_sel;
            logic                  w_wr_load;
            logic                  w_wr_ctrl;
            logic                  w_wr_stat;
            logic                  w_tick;
            logic                  w_run;
            logic                  w_ovr_keep;
            logic [DATA_WIDTH-1:0] w_ctrl_rd;
            logic [DATA_WIDTH-1:0] w_stat_rd;

            assign w_sel     = w_wr & w_ch_ok & (w_ch == CW'(g));
            assign w_wr_load = w_sel & (w_reg == REG_LOAD);
            assign w_wr_ctrl = w_sel & (w_reg == REG_CTRL);
            assign w_wr_stat = w_sel & (w_reg == REG_STATUS);
            assign w_tick    = r_en & (r_pcnt == r_pre);

            // Counting proceeds unless a LOAD write, a FORCE, or a CTRL
            // write clearing EN takes priority on this edge.
            assign w_run = r_en & ~w_wr_load
                         & ~(w_wr_ctrl & (S_PWDATA[3] | ~S_PWDATA[0]));

            // OVR after a concurrent W1C, before any expiry contribution.
            assign w_ovr_keep = r_ovr & ~(w_wr_stat & S_PWDATA[1]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_load  <= '0;
                    r_count <= '0;
                    r_pcnt  <= '0;
                    r_pre   <= '0;
                    r_en    <= 1'b0;
                    r_per   <= 1'b0;
                    r_ie    <= 1'b0;
                    r_pend  <= 1'b0;
                    r_ovr   <= 1'b0;
                end else begin
                    if (w_wr_stat) begin
                        r_pend <= r_pend & ~S_PWDATA[0];
                        r_ovr  <= w_ovr_keep;
                    end

                    if (w_wr_ctrl) begin
                        r_en  <= S_PWDATA[0];
                        r_per <= S_PWDATA[1];
                        r_ie  <= S_PWDATA[2];
                        r_pre <= S_PWDATA[15:8];
                        if (S_PWDATA[3]) begin
                            r_count <= r_load;
                            r_pcnt  <= '0;
                        end else if (S_PWDATA[0] & ~r_en) begin
                            r_pcnt <= '0;
                        end
                    end

                    if (w_wr_load) begin
                        r_load  <= S_PWDATA;
                        r_count <= S_PWDATA;
                        r_pcnt  <= '0;
                    end

                    // Placed last so an expiry's PEND set and one-shot EN
                    // clear override the bus writes above.
                    if (w_run) begin
                        if (w_tick) begin
                            r_pcnt <= '0;
                            if (r_count != '0) begin
                                r_count <= r_count - DATA_WIDTH'(1);
                            end else begin
                                r_pend <= 1'b1;
                                r_ovr  <= w_ovr_keep | r_pend;
                                if (r_per) begin
                                    r_count <= r_load;
                                end else begin
                                    r_en <= 1'b0;
                                end
                            end
                        end else begin
                            r_pcnt <= r_pcnt + 8'd1;
                        end
                    end
                end
            end

            assign w_ctrl_rd = DATA_WIDTH'({r_pre, 5'b0, r_ie, r_per, r_en});
            assign w_stat_rd = DATA_WIDTH'({r_ovr, r_pend});

            assign w_rd[g] = (w_reg == REG_LOAD)  ? r_load    :
                             (w_reg == REG_COUNT) ? r_count   :
                             (w_reg == REG_CTRL)  ? w_ctrl_rd :
                                                    w_stat_rd;

            assign irq[g] = r_pend & r_ie;
            assign int_data[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(g + 1);
        end
    endgenerate

    always_comb begin
        S_PRDATA = '0;
        if (w_access && w_ch_ok) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (w_ch == CW'(k)) begin
                    S_PRDATA = w_rd[k];
                end
            end
        end
    end

endmodule
